// File: rtl/obj_pkg.sv
// Shared types for the OBJ (sprite) pixel pipeline.
//   obj_desc_t       : one sprite descriptor as latched by the walker
//   SCREEN_W_DEFAULT : visible pixels per scanline
//   walk_state_e     : walker FSM states
package obj_pkg;

    localparam int SCREEN_W_DEFAULT = 240;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [7:0] hsize;
        logic [7:0] vsize;
        logic       hflip;
        logic       vflip;
        logic [6:0] id;
    } obj_desc_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WALK = 1'b1
    } walk_state_e;

endpackage

// File: rtl/obj_line_hit.sv
// Combinational scanline/sprite vertical intersection test.
// Ports:
//   scanline [7:0] in  : current line
//   y        [7:0] in  : sprite top row (wraps mod 256)
//   vsize    [7:0] in  : sprite height
//   dy       [7:0] out : row inside the sprite, scanline - y (wrapping)
//   hit          out   : scanline falls inside the sprite
module obj_line_hit (
    input  logic [7:0] scanline,
    input  logic [7:0] y,
    input  logic [7:0] vsize,
    output logic [7:0] dy,
    output logic       hit
);

    // Wrapping subtraction makes sprites that straddle line 255/0 work
    // without any special case.
    always_comb begin
        dy  = scanline - y;
        hit = (dy < vsize);
    end

endmodule

// File: rtl/obj_pixel_walker.sv
// Per-scanline OBJ pixel sequencer. Accepts one sprite descriptor at a
// time, tests it against the scanline and, on a hit, walks the sprite's
// columns one per cycle, emitting raw (unflipped) in-sprite coordinates
// plus latched attributes for the downstream flip unit.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   scanline [7:0]             : current line (stable while busy)
//   line_start                 : abort pulse, highest priority
//   desc_valid / desc_ready    : descriptor handshake
//   desc_x/y/hsize/vsize/hflip/vflip/id : descriptor fields
//   pix_valid / pix_ready      : pixel handshake
//   pix_x/pix_y [5:0]          : in-sprite column / row
//   pix_hsize/vsize/hflip/vflip/id : latched descriptor attributes
//   pix_screen_x [7:0]         : destination column, < SCREEN_W when valid
//   pix_last                   : final sprite column is being presented
//   busy                       : walker in WALK
module obj_pixel_walker
    import obj_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] scanline,
    input  logic       line_start,
    input  logic       desc_valid,
    output logic       desc_ready,
    input  logic [8:0] desc_x,
    input  logic [7:0] desc_y,
    input  logic [7:0] desc_hsize,
    input  logic [7:0] desc_vsize,
    input  logic       desc_hflip,
    input  logic       desc_vflip,
    input  logic [6:0] desc_id,
    output logic       pix_valid,
    input  logic       pix_ready,
    output logic [5:0] pix_x,
    output logic [5:0] pix_y,
    output logic [7:0] pix_hsize,
    output logic [7:0] pix_vsize,
    output logic       pix_hflip,
    output logic       pix_vflip,
    output logic [6:0] pix_id,
    output logic [7:0] pix_screen_x,
    output logic       pix_last,
    output logic       busy
);

    walk_state_e state;
    obj_desc_t   desc_q;
    obj_desc_t   desc_in;
    logic [5:0]  x_q;
    logic [5:0]  dy_q;

    logic [7:0]  dy;
    logic        hit;
    logic        row_ok;
    logic        accept;
    logic [8:0]  sx;
    logic        on_screen;
    logic        at_last;
    logic        advance;

    assign desc_in = '{x: desc_x, y: desc_y, hsize: desc_hsize, vsize: desc_vsize,
                       hflip: desc_hflip, vflip: desc_vflip, id: desc_id};

    obj_line_hit u_line_hit (
        .scanline (scanline),
        .y        (desc_y),
        .vsize    (desc_vsize),
        .dy       (dy),
        .hit      (hit)
    );

    // Rows beyond 63 only arise from out-of-range heights; treat them as
    // misses rather than emit a truncated row index.
    assign row_ok = hit & (dy[7:6] == 2'b00);

    assign desc_ready = (state == ST_IDLE) & ~line_start;
    assign accept     = desc_valid & desc_ready;

    // Screen column wraps mod 512 so sprites at x >= 512-W enter from the left.
    assign sx        = desc_q.x + {3'b000, x_q};
    assign on_screen = (sx < 9'(SCREEN_W));
    assign at_last   = ({2'b00, x_q} == (desc_q.hsize - 8'd1));

    assign busy      = (state == ST_WALK);
    assign pix_valid = busy & on_screen;
    // Off-screen columns are skipped without waiting for the consumer.
    assign advance   = busy & (~on_screen | pix_ready);

    assign pix_x        = x_q;
    assign pix_y        = dy_q;
    assign pix_hsize    = desc_q.hsize;
    assign pix_vsize    = desc_q.vsize;
    assign pix_hflip    = desc_q.hflip;
    assign pix_vflip    = desc_q.vflip;
    assign pix_id       = desc_q.id;
    assign pix_screen_x = sx[7:0];
    assign pix_last     = pix_valid & at_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            x_q    <= '0;
            dy_q   <= '0;
            desc_q <= '0;
        end else if (line_start) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept && row_ok) begin
                        desc_q <= desc_in;
                        dy_q   <= dy[5:0];
                        x_q    <= '0;
                        state  <= ST_WALK;
                    end
                end
                ST_WALK: begin
                    if (advance) begin
                        if (at_last) begin
                            state <= ST_IDLE;
                        end else begin
                            x_q <= x_q + 6'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
